// File: rtl/cpu_pkg.sv
// Shared CPU decode constants, field helpers and mul/div FSM encoding.
package cpu_pkg;

  localparam int unsigned INSN_W   = 32;
  localparam int unsigned FIELD_W  = 5;
  localparam int unsigned OPC_LSB  = 27;
  localparam int unsigned RD_LSB   = 22;
  localparam int unsigned RS_LSB   = 17;
  localparam int unsigned RT_LSB   = 12;
  localparam int unsigned ALU_LSB  = 2;

  localparam logic [FIELD_W-1:0] OP_RTYPE = 5'b00000;
  localparam logic [FIELD_W-1:0] OP_LW    = 5'b01000;
  localparam logic [FIELD_W-1:0] ALU_MUL  = 5'b00110;
  localparam logic [FIELD_W-1:0] ALU_DIV  = 5'b00111;

  localparam logic [INSN_W-1:0] NOP = '0;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  function automatic logic [FIELD_W-1:0] insn_opcode(input logic [INSN_W-1:0] insn);
    return insn[OPC_LSB +: FIELD_W];
  endfunction

  function automatic logic [FIELD_W-1:0] insn_rd(input logic [INSN_W-1:0] insn);
    return insn[RD_LSB +: FIELD_W];
  endfunction

  function automatic logic [FIELD_W-1:0] insn_rs(input logic [INSN_W-1:0] insn);
    return insn[RS_LSB +: FIELD_W];
  endfunction

  function automatic logic [FIELD_W-1:0] insn_rt(input logic [INSN_W-1:0] insn);
    return insn[RT_LSB +: FIELD_W];
  endfunction

  function automatic logic [FIELD_W-1:0] insn_aluop(input logic [INSN_W-1:0] insn);
    return insn[ALU_LSB +: FIELD_W];
  endfunction

  function automatic logic is_muldiv(input logic [INSN_W-1:0] insn);
    return (insn_opcode(insn) == OP_RTYPE) &&
           ((insn_aluop(insn) == ALU_MUL) || (insn_aluop(insn) == ALU_DIV));
  endfunction

  function automatic logic is_load(input logic [INSN_W-1:0] insn);
    return insn_opcode(insn) == OP_LW;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Single-operand bypass selector: XM over MW over register file; r0 reads as zero.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [FIELD_W-1:0] src,
  input  logic [WIDTH-1:0]   rf_data,
  input  logic               xm_wen,
  input  logic [FIELD_W-1:0] xm_rd,
  input  logic [WIDTH-1:0]   xm_data,
  input  logic               mw_wen,
  input  logic [FIELD_W-1:0] mw_rd,
  input  logic [WIDTH-1:0]   mw_data,
  output logic [WIDTH-1:0]   operand
);

  always_comb begin
    operand = rf_data;
    if (src == '0) begin
      operand = '0;
    end else if (xm_wen && (xm_rd == src)) begin
      operand = xm_data;
    end else if (mw_wen && (mw_rd == src)) begin
      operand = mw_data;
    end
  end

endmodule

// File: rtl/dx_operand_stage.sv
// D/X pipeline register with operand forwarding, load-use stall and mul/div
// execute interlock.
module dx_operand_stage
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSN_W-1:0]  fd_insn,
  input  logic [INSN_W-1:0]  fd_pc,
  input  logic [WIDTH-1:0]   rf_dataA,
  input  logic [WIDTH-1:0]   rf_dataB,
  input  logic               flush,
  input  logic [FIELD_W-1:0] xm_rd,
  input  logic               xm_wen,
  input  logic [WIDTH-1:0]   xm_result,
  input  logic [FIELD_W-1:0] mw_rd,
  input  logic               mw_wen,
  input  logic [WIDTH-1:0]   mw_data,
  output logic               stall_fd,
  output logic [INSN_W-1:0]  dx_insn,
  output logic [INSN_W-1:0]  dx_pc,
  output logic [WIDTH-1:0]   data_operandA,
  output logic [WIDTH-1:0]   data_operandB,
  output logic               md_busy,
  output logic               md_done
);

  localparam int unsigned CNT_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rf_a_q, rf_b_q, hold_a_q, hold_b_q;
  logic [WIDTH-1:0] fwd_a, fwd_b;
  logic             md_run, md_last, md_entry, load_use, kill;

  fwd_mux #(.WIDTH(WIDTH)) u_fwd_a (
    .src(insn_rs(dx_insn)), .rf_data(rf_a_q),
    .xm_wen(xm_wen), .xm_rd(xm_rd), .xm_data(xm_result),
    .mw_wen(mw_wen), .mw_rd(mw_rd), .mw_data(mw_data),
    .operand(fwd_a)
  );

  fwd_mux #(.WIDTH(WIDTH)) u_fwd_b (
    .src(insn_rt(dx_insn)), .rf_data(rf_b_q),
    .xm_wen(xm_wen), .xm_rd(xm_rd), .xm_data(xm_result),
    .mw_wen(mw_wen), .mw_rd(mw_rd), .mw_data(mw_data),
    .operand(fwd_b)
  );

  // Hazard decode; cnt_q counts the RUN cycles still to go after the current one.
  always_comb begin
    md_run   = (state_q == MD_RUN);
    md_last  = md_run && (cnt_q == '0);
    md_entry = !md_run && is_muldiv(dx_insn);
    load_use = is_load(dx_insn) && (insn_rd(dx_insn) != '0) &&
               ((insn_rd(dx_insn) == insn_rs(fd_insn)) ||
                (insn_rd(dx_insn) == insn_rt(fd_insn)));
    kill     = reset || flush;
  end

  assign stall_fd      = !kill && (md_entry || (md_run && !md_last) || load_use);
  assign md_busy       = md_run || md_entry;
  assign md_done       = md_last && !kill;
  assign data_operandA = md_run ? hold_a_q : fwd_a;
  assign data_operandB = md_run ? hold_b_q : fwd_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      dx_insn  <= NOP;
      dx_pc    <= '0;
      rf_a_q   <= '0;
      rf_b_q   <= '0;
      hold_a_q <= '0;
      hold_b_q <= '0;
    end else if (flush) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      dx_insn <= NOP;
      dx_pc   <= '0;
      rf_a_q  <= '0;
      rf_b_q  <= '0;
    end else if (md_entry) begin
      state_q  <= MD_RUN;
      cnt_q    <= CNT_W'(MD_CYCLES - 2);
      hold_a_q <= fwd_a;
      hold_b_q <= fwd_b;
    end else if (md_run && !md_last) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else begin
      state_q <= MD_IDLE;
      if (load_use) begin
        dx_insn <= NOP;
        dx_pc   <= '0;
        rf_a_q  <= '0;
        rf_b_q  <= '0;
      end else begin
        dx_insn <= fd_insn;
        dx_pc   <= fd_pc;
        rf_a_q  <= rf_dataA;
        rf_b_q  <= rf_dataB;
      end
    end
  end

endmodule

// File: tb/tb_dx_operand_stage.sv
// Self-checking bench for dx_operand_stage: vector table, directed corner
// sequences and a randomized run against a behavioural pipeline model.
module tb_dx_operand_stage;

  localparam int unsigned W   = 32;
  localparam int unsigned MDC = 32;
  localparam logic [4:0] T_LW  = 5'b01000;
  localparam logic [4:0] T_MUL = 5'b00110;
  localparam logic [4:0] T_DIV = 5'b00111;
  localparam logic [4:0] T_ADD = 5'b00000;

  logic          clock = 1'b0;
  logic          reset, flush, xm_wen, mw_wen;
  logic [31:0]   fd_insn, fd_pc;
  logic [W-1:0]  rf_dataA, rf_dataB, xm_result, mw_data;
  logic [4:0]    xm_rd, mw_rd;
  logic          stall_fd, md_busy, md_done;
  logic [31:0]   dx_insn, dx_pc;
  logic [W-1:0]  data_operandA, data_operandB;

  int total = 0;
  int bad   = 0;

  dx_operand_stage #(.WIDTH(W), .MD_CYCLES(MDC)) dut (
    .clock(clock), .reset(reset), .fd_insn(fd_insn), .fd_pc(fd_pc),
    .rf_dataA(rf_dataA), .rf_dataB(rf_dataB), .flush(flush),
    .xm_rd(xm_rd), .xm_wen(xm_wen), .xm_result(xm_result),
    .mw_rd(mw_rd), .mw_wen(mw_wen), .mw_data(mw_data),
    .stall_fd(stall_fd), .dx_insn(dx_insn), .dx_pc(dx_pc),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [31:0] r_insn(input int rd, input int rs, input int rt,
                                         input logic [4:0] aluop);
    return {5'b00000, 5'(rd), 5'(rs), 5'(rt), 5'b00000, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] lw_insn(input int rd, input int rs, input int imm);
    return {T_LW, 5'(rd), 5'(rs), 17'(imm)};
  endfunction

  function automatic logic [W-1:0] fwd_ref(input logic [4:0] src, input logic [W-1:0] rf);
    if (src == 5'd0) return '0;
    if (xm_wen && xm_rd == src) return xm_result;
    if (mw_wen && mw_rd == src) return mw_data;
    return rf;
  endfunction

  function automatic logic ref_is_md(input logic [31:0] i);
    return (i[31:27] == 5'b00000) && (i[6:2] == T_MUL || i[6:2] == T_DIV);
  endfunction

  task automatic clear_bypass();
    xm_wen = 0; xm_rd = 0; xm_result = 0;
    mw_wen = 0; mw_rd = 0; mw_data = 0;
  endtask

  task automatic do_reset();
    reset = 1; flush = 0;
    fd_insn = 0; fd_pc = 0; rf_dataA = 0; rf_dataB = 0;
    clear_bypass();
    tick(); tick();
    reset = 0;
  endtask

  typedef struct {
    logic [4:0]  rs, rt;
    logic [31:0] rfa, rfb;
    logic        xw; logic [4:0] xr; logic [31:0] xd;
    logic        mwe; logic [4:0] mr; logic [31:0] md;
    logic [31:0] ea, eb;
  } fvec_t;

  fvec_t tbl[6];

  // Behavioural model state: what DX holds and how long a mul/div has occupied it.
  logic [31:0] m_insn, m_pc, m_rfa, m_rfb, m_ha, m_hb;
  int          m_pos;

  initial begin
    int busy_n, stall_n, done_n, done_at;
    logic [31:0] add_i, lw_i, exp_a, exp_b;
    logic prev_stall, lu, kill, is_md, mstall, e_stall, e_done;
    logic [4:0] rd;
    int sel;

    do_reset();
    settle();
    chk("rst_insn", dx_insn, 32'h0);
    chk("rst_pc", dx_pc, 32'h0);
    chk("rst_opA", data_operandA, 32'h0);
    chk("rst_opB", data_operandB, 32'h0);
    chk("rst_stall", {31'b0, stall_fd}, 32'h0);
    chk("rst_busy", {31'b0, md_busy}, 32'h0);
    chk("rst_done", {31'b0, md_done}, 32'h0);

    // Forwarding vectors
    tbl[0] = '{5'd1, 5'd2, 32'd5, 32'd7, 1'b1, 5'd1, 32'd100, 1'b1, 5'd2, 32'd200, 32'd100, 32'd200};
    tbl[1] = '{5'd1, 5'd2, 32'd5, 32'd7, 1'b1, 5'd1, 32'd100, 1'b1, 5'd1, 32'd300, 32'd100, 32'd7};
    tbl[2] = '{5'd0, 5'd0, 32'd5, 32'd7, 1'b1, 5'd0, 32'd55, 1'b1, 5'd0, 32'd66, 32'd0, 32'd0};
    tbl[3] = '{5'd1, 5'd2, 32'd5, 32'd7, 1'b0, 5'd1, 32'd100, 1'b1, 5'd1, 32'd300, 32'd300, 32'd7};
    tbl[4] = '{5'd1, 5'd2, 32'd5, 32'd7, 1'b1, 5'd9, 32'd100, 1'b1, 5'd10, 32'd300, 32'd5, 32'd7};
    tbl[5] = '{5'd2, 5'd2, 32'd5, 32'd7, 1'b1, 5'd2, 32'hAA, 1'b1, 5'd2, 32'hBB, 32'hAA, 32'hAA};
    for (int i = 0; i < 6; i++) begin
      clear_bypass();
      fd_insn = r_insn(3, int'(tbl[i].rs), int'(tbl[i].rt), T_ADD);
      fd_pc = 32'h100 + 32'(i);
      rf_dataA = tbl[i].rfa; rf_dataB = tbl[i].rfb;
      tick();
      fd_insn = 0; fd_pc = 0;
      xm_wen = tbl[i].xw; xm_rd = tbl[i].xr; xm_result = tbl[i].xd;
      mw_wen = tbl[i].mwe; mw_rd = tbl[i].mr; mw_data = tbl[i].md;
      settle();
      chk($sformatf("fwd%0d_A", i), data_operandA, tbl[i].ea);
      chk($sformatf("fwd%0d_B", i), data_operandB, tbl[i].eb);
      chk($sformatf("fwd%0d_pc", i), dx_pc, 32'h100 + 32'(i));
      tick();
    end

    // Load-use: one stall, one bubble, then MW forward into the consumer
    do_reset();
    lw_i = lw_insn(4, 1, 0);
    add_i = r_insn(5, 4, 4, T_ADD);
    fd_insn = lw_i; fd_pc = 32'h20;
    tick();
    fd_insn = add_i; fd_pc = 32'h21;
    settle();
    chk("lu_dx_lw", dx_insn, lw_i);
    chk("lu_stall", {31'b0, stall_fd}, 32'h1);
    tick();
    settle();
    chk("lu_bubble", dx_insn, 32'h0);
    chk("lu_bubble_pc", dx_pc, 32'h0);
    chk("lu_stall_gone", {31'b0, stall_fd}, 32'h0);
    tick();
    mw_wen = 1; mw_rd = 4; mw_data = 32'h1234;
    settle();
    chk("lu_consumer", dx_insn, add_i);
    chk("lu_opA", data_operandA, 32'h1234);
    chk("lu_opB", data_operandB, 32'h1234);
    clear_bypass();

    // Mul: busy MDC cycles, stall MDC-1, one done pulse, operands held
    do_reset();
    add_i = r_insn(7, 6, 6, T_ADD);
    fd_insn = r_insn(6, 1, 2, T_MUL); fd_pc = 32'h40;
    rf_dataA = 11; rf_dataB = 22;
    tick();
    fd_insn = add_i; fd_pc = 32'h41;
    xm_wen = 1; xm_rd = 1; xm_result = 32'h50;
    busy_n = 0; stall_n = 0; done_n = 0; done_at = 0;
    for (int c = 1; c <= int'(MDC); c++) begin
      if (c == 2) begin
        xm_result = 32'h999; mw_wen = 1; mw_rd = 2; mw_data = 32'h777;
      end
      settle();
      busy_n += int'(md_busy);
      stall_n += int'(stall_fd);
      if (md_done) begin done_n++; done_at = c; end
      if (c == 1 || c == 2 || c == int'(MDC)) begin
        chk($sformatf("mul_c%0d_A", c), data_operandA, 32'h50);
        chk($sformatf("mul_c%0d_B", c), data_operandB, 32'd22);
      end
      tick();
    end
    settle();
    chk("mul_busy_cycles", 32'(busy_n), 32'(MDC));
    chk("mul_stall_cycles", 32'(stall_n), 32'(MDC - 1));
    chk("mul_done_count", 32'(done_n), 32'd1);
    chk("mul_done_cycle", 32'(done_at), 32'(MDC));
    chk("mul_next_insn", dx_insn, add_i);
    chk("mul_busy_after", {31'b0, md_busy}, 32'h0);
    clear_bypass();

    // Flush at RUN cycle 10
    do_reset();
    fd_insn = r_insn(6, 1, 2, T_DIV); fd_pc = 32'h50;
    tick();
    fd_insn = 0; fd_pc = 0;
    for (int c = 1; c < 10; c++) tick();
    flush = 1;
    settle();
    chk("fl_stall_in_cycle", {31'b0, stall_fd}, 32'h0);
    chk("fl_done_in_cycle", {31'b0, md_done}, 32'h0);
    tick();
    flush = 0;
    settle();
    chk("fl_bubble", dx_insn, 32'h0);
    chk("fl_pc", dx_pc, 32'h0);
    chk("fl_busy", {31'b0, md_busy}, 32'h0);
    chk("fl_stall", {31'b0, stall_fd}, 32'h0);
    done_n = 0;
    for (int c = 0; c < 30; c++) begin tick(); settle(); done_n += int'(md_done); end
    chk("fl_no_done", 32'(done_n), 32'h0);

    // Reset mid-RUN
    do_reset();
    fd_insn = r_insn(6, 1, 2, T_MUL); fd_pc = 32'h60; rf_dataA = 3; rf_dataB = 4;
    tick();
    fd_insn = 0;
    for (int c = 1; c < 5; c++) tick();
    reset = 1;
    tick();
    reset = 0;
    settle();
    chk("rr_insn", dx_insn, 32'h0);
    chk("rr_busy", {31'b0, md_busy}, 32'h0);
    chk("rr_stall", {31'b0, stall_fd}, 32'h0);
    chk("rr_done", {31'b0, md_done}, 32'h0);
    chk("rr_opA", data_operandA, 32'h0);
    tick(); settle();
    chk("rr_busy_later", {31'b0, md_busy}, 32'h0);

    // Reset during load-use
    do_reset();
    fd_insn = lw_insn(4, 1, 0);
    tick();
    fd_insn = r_insn(5, 4, 4, T_ADD);
    settle();
    chk("rl_pre_stall", {31'b0, stall_fd}, 32'h1);
    reset = 1;
    tick();
    reset = 0;
    settle();
    chk("rl_insn", dx_insn, 32'h0);
    chk("rl_pc", dx_pc, 32'h0);
    chk("rl_stall", {31'b0, stall_fd}, 32'h0);
    chk("rl_busy", {31'b0, md_busy}, 32'h0);

    // Randomized run against the model
    do_reset();
    m_insn = 0; m_pc = 0; m_rfa = 0; m_rfb = 0; m_ha = 0; m_hb = 0; m_pos = 0;
    prev_stall = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!prev_stall) begin
        sel = int'($urandom_range(0, 19));
        if (sel < 8)
          fd_insn = r_insn(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 7)), T_ADD);
        else if (sel < 12)
          fd_insn = lw_insn(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 255)));
        else if (sel == 12)
          fd_insn = r_insn(int'($urandom_range(1, 7)), int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 7)), T_MUL);
        else if (sel == 13)
          fd_insn = r_insn(int'($urandom_range(1, 7)), int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 7)), T_DIV);
        else if (sel < 16)
          fd_insn = 0;
        else
          fd_insn = $urandom;
        fd_pc = $urandom;
        rf_dataA = $urandom;
        rf_dataB = $urandom;
      end
      xm_wen = 1'($urandom_range(0, 1)); xm_rd = 5'($urandom_range(0, 7)); xm_result = $urandom;
      mw_wen = 1'($urandom_range(0, 1)); mw_rd = 5'($urandom_range(0, 7)); mw_data = $urandom;
      flush = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 299) == 0);
      settle();

      is_md  = ref_is_md(m_insn);
      kill   = reset || flush;
      rd     = m_insn[26:22];
      lu     = (m_insn[31:27] == T_LW) && rd != 0 && (rd == fd_insn[21:17] || rd == fd_insn[16:12]);
      mstall = is_md && m_pos < int'(MDC);
      e_stall = !kill && (mstall || lu);
      e_done  = !kill && is_md && m_pos == int'(MDC);
      exp_a = (is_md && m_pos >= 2) ? m_ha : fwd_ref(m_insn[21:17], m_rfa);
      exp_b = (is_md && m_pos >= 2) ? m_hb : fwd_ref(m_insn[16:12], m_rfb);

      chk("rnd_insn", dx_insn, m_insn);
      chk("rnd_pc", dx_pc, m_pc);
      chk("rnd_opA", data_operandA, exp_a);
      chk("rnd_opB", data_operandB, exp_b);
      chk("rnd_stall", {31'b0, stall_fd}, {31'b0, e_stall});
      chk("rnd_busy", {31'b0, md_busy}, {31'b0, is_md});
      chk("rnd_done", {31'b0, md_done}, {31'b0, e_done});

      if (reset) begin
        m_insn = 0; m_pc = 0; m_rfa = 0; m_rfb = 0; m_pos = 0;
      end else if (flush || (!mstall && lu)) begin
        m_insn = 0; m_pc = 0; m_rfa = 0; m_rfb = 0; m_pos = 0;
      end else if (mstall) begin
        if (m_pos == 1) begin m_ha = exp_a; m_hb = exp_b; end
        m_pos++;
      end else begin
        m_insn = fd_insn; m_pc = fd_pc; m_rfa = rf_dataA; m_rfb = rf_dataB; m_pos = 1;
      end
      prev_stall = e_stall;
      tick();
    end
    reset = 0; flush = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
